// File: rtl/memsize_probe_ctrl_pkg.sv
// Shared configuration for the boot-time SRAM size probe: states, size codes,
// signature bytes and the first alias boundary.
package memsize_probe_ctrl_pkg;

  localparam int unsigned ADDR_W = 22;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SAVE0,
    ST_WSIG,
    ST_WBND,
    ST_RCHK,
    ST_RESTORE,
    ST_REPORT,
    ST_DONE
  } probe_state_e;

  typedef enum logic [1:0] {
    SIZE_512K = 2'b00,
    SIZE_1M   = 2'b01,
    SIZE_2M   = 2'b10,
    SIZE_4M   = 2'b11
  } size_code_e;

  localparam logic [7:0]        SIG_BASE     = 8'hA5;
  localparam logic [7:0]        SIG_BND      = 8'h5A;
  localparam logic [ADDR_W-1:0] BND_BASE     = 22'h080000;
  localparam logic [2:0]        LAST_BND_IDX = 3'd2;

  function automatic logic [ADDR_W-1:0] bnd_addr(input logic [2:0] idx);
    return BND_BASE << idx;
  endfunction

endpackage

// File: rtl/memsize_probe_ctrl_if.sv
// SRAM request/acknowledge bus between the probe controller and the memory.
interface memsize_probe_ctrl_if;
  import memsize_probe_ctrl_pkg::*;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;
  logic              mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/memsize_probe_ctrl_mem_access_seq.sv
// Single SRAM access sequencer: holds a request until acked, with an ack
// watchdog; reports completion or timeout as one-cycle pulses.
module mem_access_seq
  import memsize_probe_ctrl_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 go,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [7:0]           wdata,
  output logic                 done,
  output logic                 timeout,
  output logic [7:0]           rdata,
  memsize_probe_ctrl_if.master mem
);

  localparam logic [7:0] WD_LAST = 8'(ACK_TIMEOUT - 1);

  logic              req_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic [7:0]        wd_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wd_cnt  <= '0;
      done    <= 1'b0;
      timeout <= 1'b0;
      rdata   <= '0;
    end else begin
      done    <= 1'b0;
      timeout <= 1'b0;
      if (req_q) begin
        // an ack on the final watchdog cycle still counts as success
        if (mem.mem_ack) begin
          req_q <= 1'b0;
          done  <= 1'b1;
          rdata <= mem.mem_rdata;
        end else if (wd_cnt == WD_LAST) begin
          req_q   <= 1'b0;
          timeout <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + 8'd1;
        end
      end else if (go) begin
        req_q   <= 1'b1;
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        wd_cnt  <= '0;
      end
    end
  end

  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: rtl/memsize_probe_ctrl.sv
// Boot-time SRAM size probe: writes a signature at 0, then probes power-of-two
// boundaries for aliasing and reports the detected size code.
module memsize_probe_ctrl
  import memsize_probe_ctrl_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 poweron_rst_n,
  input  logic                 in_boot_mode,
  input  logic                 start,
  memsize_probe_ctrl_if.master mem,
  output logic                 cfg_we,
  output logic [1:0]           cfg_data,
  output logic                 busy,
  output logic                 error
);

  probe_state_e state, state_n;
  logic [2:0]   idx, idx_n;
  logic [7:0]   save_q, save_n;
  size_code_e   code_q, code_n;
  size_code_e   cfg_q, cfg_n;
  logic         lost_q, lost_n;
  logic         err_q, err_n;

  logic              acc_go;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [7:0]        acc_wdata;
  logic              acc_done;
  logic              acc_timeout;
  logic [7:0]        acc_rdata;

  mem_access_seq #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_seq (
    .clk     (clk),
    .rst_n   (poweron_rst_n),
    .go      (acc_go),
    .we      (acc_we),
    .addr    (acc_addr),
    .wdata   (acc_wdata),
    .done    (acc_done),
    .timeout (acc_timeout),
    .rdata   (acc_rdata),
    .mem     (mem)
  );

  always_ff @(posedge clk) begin
    if (!poweron_rst_n) begin
      state  <= ST_IDLE;
      idx    <= '0;
      save_q <= '0;
      code_q <= SIZE_512K;
      cfg_q  <= SIZE_512K;
      lost_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      save_q <= save_n;
      code_q <= code_n;
      cfg_q  <= cfg_n;
      lost_q <= lost_n;
      err_q  <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    idx_n     = idx;
    save_n    = save_q;
    code_n    = code_q;
    cfg_n     = cfg_q;
    lost_n    = lost_q;
    err_n     = err_q;
    acc_go    = 1'b0;
    acc_we    = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;

    // losing boot mode lets the running access finish, then diverts to restore
    if ((state inside {ST_SAVE0, ST_WSIG, ST_WBND, ST_RCHK, ST_RESTORE}) && !in_boot_mode) begin
      lost_n = 1'b1;
      err_n  = 1'b1;
    end

    case (state)
      ST_IDLE: begin
        if (start && in_boot_mode) begin
          state_n = ST_SAVE0;
          idx_n   = '0;
          lost_n  = 1'b0;
          err_n   = 1'b0;
        end
      end
      ST_SAVE0, ST_WSIG, ST_WBND, ST_RCHK, ST_RESTORE: begin
        if (acc_timeout) begin
          err_n   = 1'b1;
          code_n  = SIZE_512K;
          state_n = ST_REPORT;
        end else if (acc_done) begin
          case (state)
            ST_SAVE0: begin
              save_n  = acc_rdata;
              state_n = lost_n ? ST_RESTORE : ST_WSIG;
            end
            ST_WSIG: state_n = lost_n ? ST_RESTORE : ST_WBND;
            ST_WBND: state_n = lost_n ? ST_RESTORE : ST_RCHK;
            ST_RCHK: begin
              if (lost_n) begin
                state_n = ST_RESTORE;
              end else if (acc_rdata != SIG_BASE) begin
                code_n  = size_code_e'(idx[1:0]);
                state_n = ST_RESTORE;
              end else if (idx < LAST_BND_IDX) begin
                idx_n   = 3'(idx + 3'd1);
                state_n = ST_WBND;
              end else begin
                code_n  = SIZE_4M;
                state_n = ST_RESTORE;
              end
            end
            default: state_n = ST_REPORT;
          endcase
        end
      end
      ST_REPORT: state_n = ST_DONE;
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase

    // each access is launched on the transition into its state
    if (state_n != state) begin
      case (state_n)
        ST_SAVE0: begin
          acc_go = 1'b1;
        end
        ST_WSIG: begin
          acc_go    = 1'b1;
          acc_we    = 1'b1;
          acc_wdata = SIG_BASE;
        end
        ST_WBND: begin
          acc_go    = 1'b1;
          acc_we    = 1'b1;
          acc_addr  = bnd_addr(idx_n);
          acc_wdata = SIG_BND;
        end
        ST_RCHK: begin
          acc_go = 1'b1;
        end
        ST_RESTORE: begin
          acc_go    = 1'b1;
          acc_we    = 1'b1;
          acc_wdata = save_n;
        end
        ST_REPORT: begin
          if (!lost_n) cfg_n = code_n;
        end
        default: ;
      endcase
    end
  end

  assign cfg_we   = (state == ST_REPORT) && !lost_q;
  assign cfg_data = cfg_q;
  assign busy     = (state != ST_IDLE);
  assign error    = err_q;

endmodule

// File: tb/tb_memsize_probe_ctrl.sv
// Bench for memsize_probe_ctrl: SRAM model with aliasing and random ack delay,
// scoreboard of expected size reports, directed fault cases plus random probes.
module tb_memsize_probe_ctrl;
  import memsize_probe_ctrl_pkg::*;

  localparam int unsigned TO = 16;

  logic       clk = 1'b0;
  logic       poweron_rst_n = 1'b0;
  logic       in_boot_mode = 1'b1;
  logic       start = 1'b0;
  logic       cfg_we;
  logic [1:0] cfg_data;
  logic       busy;
  logic       error;

  memsize_probe_ctrl_if mem_if();

  memsize_probe_ctrl #(.ACK_TIMEOUT(TO)) dut (
    .clk           (clk),
    .poweron_rst_n (poweron_rst_n),
    .in_boot_mode  (in_boot_mode),
    .start         (start),
    .mem           (mem_if),
    .cfg_we        (cfg_we),
    .cfg_data      (cfg_data),
    .busy          (busy),
    .error         (error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // ---------------- SRAM model ----------------
  logic [7:0]  sram[int unsigned];
  int unsigned msize = 32'h400000;

  function automatic logic [7:0] sram_rd(input int unsigned a);
    int unsigned k = a % msize;
    return sram.exists(k) ? sram[k] : 8'h00;
  endfunction

  // Reference: the first probe boundary that wraps onto byte 0 names the size.
  function automatic int unsigned ref_code(input int unsigned size);
    for (int unsigned i = 0; i < 3; i++)
      if (((32'h80000 << i) % size) == 0) return i;
    return 3;
  endfunction

  function automatic int ref_accesses(input int unsigned code);
    int unsigned probes = (code == 3) ? 3 : code + 1;
    return 3 + 2 * int'(probes);
  endfunction

  // ---------------- responder / bus monitor ----------------
  int          acc_cnt = 0;
  int          hold_idx = -1;
  int          drop_idx = -1;
  int          hold_cycles = 0;
  int          wait_cnt = 0;
  int          cur_delay = 0;
  int          max_delay = 5;
  bit          stray_en = 0;
  bit          drop_ok = 0;
  int          proto_errs = 0;
  bit          prev_req = 0;
  bit          prev_ack = 0;
  logic [30:0] prev_bus = '0;

  initial begin
    mem_if.mem_ack   = 1'b0;
    mem_if.mem_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (prev_req && prev_ack && mem_if.mem_req) proto_errs++;
      if (prev_req && !prev_ack && !mem_if.mem_req && !drop_ok) proto_errs++;
      if (prev_req && !prev_ack && mem_if.mem_req &&
          {mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata} != prev_bus) proto_errs++;
      prev_req = mem_if.mem_req;
      prev_bus = {mem_if.mem_we, mem_if.mem_addr, mem_if.mem_wdata};
      mem_if.mem_ack   = 1'b0;
      mem_if.mem_rdata = 8'($urandom);
      if (mem_if.mem_req) begin
        if (acc_cnt == drop_idx) begin
          in_boot_mode = 1'b0;
          drop_idx = -1;
        end
        if (acc_cnt == hold_idx) begin
          hold_cycles++;
        end else if (wait_cnt < cur_delay) begin
          wait_cnt++;
        end else begin
          if (mem_if.mem_we) sram[int'(mem_if.mem_addr) % msize] = mem_if.mem_wdata;
          else mem_if.mem_rdata = sram_rd(int'(mem_if.mem_addr));
          mem_if.mem_ack = 1'b1;
          acc_cnt++;
          wait_cnt  = 0;
          cur_delay = $urandom_range(0, max_delay);
        end
      end else if (stray_en && $urandom_range(0, 7) == 0) begin
        mem_if.mem_ack = 1'b1;
      end
      prev_ack = mem_if.mem_ack && mem_if.mem_req;
    end
  end

  // ---------------- report scoreboard ----------------
  logic [1:0] exp_q[$];
  int         n_cfg = 0;
  int         unexp_cfg = 0;
  int         width_errs = 0;
  bit         prev_cfg_we = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (cfg_we) begin
        n_cfg++;
        if (prev_cfg_we) width_errs++;
        if (exp_q.size() == 0) unexp_cfg++;
        else check("cfg_data_report", cfg_data, exp_q.pop_front());
      end
      prev_cfg_we = cfg_we;
    end
  end

  // ---------------- stimulus ----------------
  int unsigned last_code = 0;

  task automatic wait_idle(input string name);
    for (int c = 0; c < 3000 && busy; c++) @(negedge clk);
    check(name, busy, 0);
  endtask

  // mode 0: normal, 1: ack withheld on first WBND, 2: boot mode dropped in RCHK
  task automatic run_probe(input int unsigned size, input int mode);
    logic [7:0]  orig;
    int unsigned code;
    int          cfg_before;
    sram.delete();
    msize       = size;
    orig        = 8'($urandom);
    sram[0]     = orig;
    acc_cnt     = 0;
    hold_cycles = 0;
    wait_cnt    = 0;
    cur_delay   = $urandom_range(0, max_delay);
    hold_idx    = (mode == 1) ? 2 : -1;
    drop_idx    = (mode == 2) ? 3 : -1;
    drop_ok     = (mode == 1);
    code        = ref_code(size);
    cfg_before  = n_cfg;
    if (mode == 0) begin
      exp_q.push_back(2'(code));
      last_code = code;
    end else if (mode == 1) begin
      exp_q.push_back(2'b00);
      last_code = 0;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    wait_idle("probe_completes");
    check("bus_protocol_errs", proto_errs, 0);
    check("cfg_data_held", cfg_data, last_code);
    check("queue_drained", exp_q.size(), 0);
    case (mode)
      0: begin
        check("access_count", acc_cnt, ref_accesses(code));
        check("byte0_restored", sram_rd(0), orig);
        check("error_clear", error, 0);
        check("cfg_pulses", n_cfg - cfg_before, 1);
      end
      1: begin
        check("timeout_req_cycles", hold_cycles, TO);
        check("timeout_access_count", acc_cnt, 2);
        check("timeout_no_restore", sram_rd(0), SIG_BASE);
        check("timeout_error", error, 1);
        check("timeout_cfg_pulses", n_cfg - cfg_before, 1);
      end
      default: begin
        check("bootdrop_access_count", acc_cnt, 5);
        check("bootdrop_restored", sram_rd(0), orig);
        check("bootdrop_error", error, 1);
        check("bootdrop_no_cfg", n_cfg - cfg_before, 0);
        in_boot_mode = 1'b1;
      end
    endcase
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mem_req"}, mem_if.mem_req, 0);
    check({tag, "_mem_we"}, mem_if.mem_we, 0);
    check({tag, "_mem_addr"}, mem_if.mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_if.mem_wdata, 0);
    check({tag, "_cfg_we"}, cfg_we, 0);
    check({tag, "_cfg_data"}, cfg_data, 0);
    check({tag, "_error"}, error, 0);
  endtask

  initial begin
    bit          seen;
    bit          found;
    logic [7:0]  orig;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    poweron_rst_n = 1'b1;
    @(negedge clk);

    // start ignored outside boot mode
    in_boot_mode = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    repeat (20) begin
      if (busy || mem_if.mem_req) seen = 1;
      @(negedge clk);
    end
    check("no_boot_ignored", seen, 0);
    in_boot_mode = 1'b1;

    run_probe(32'h080000, 0);
    run_probe(32'h200000, 0);
    run_probe(32'h400000, 0);
    run_probe(32'h400000, 1);
    run_probe(32'h100000, 0);
    run_probe(32'h400000, 2);

    // reset while the signature write is outstanding
    sram.delete();
    msize    = 32'h400000;
    orig     = 8'($urandom);
    sram[0]  = orig;
    acc_cnt  = 0;
    wait_cnt = 0;
    hold_idx = 1;
    drop_idx = -1;
    drop_ok  = 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 200; c++) begin
      if (mem_if.mem_req && mem_if.mem_we && mem_if.mem_wdata == SIG_BASE) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("wsig_reached", found, 1);
    poweron_rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_reset_outputs("midrst");
    @(negedge clk);
    poweron_rst_n = 1'b1;
    last_code = 0;
    check("midrst_byte0_untouched", sram_rd(0), orig);
    run_probe(32'h400000, 0);

    // random sizes with stray acks between accesses
    stray_en = 1;
    for (int i = 0; i < 8; i++) run_probe(32'h080000 << $urandom_range(0, 3), 0);
    stray_en = 0;

    check("cfg_unexpected_pulses", unexp_cfg, 0);
    check("cfg_pulse_width_errs", width_errs, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
